mem_access_unit: RTL and testbench

- Data-memory responder for the CPU's load/store control signals: memRead, memWrite, memDataSize and memBitExt.
- Converts each byte, halfword or word access into one word-wide request on a ready/ack data-memory port. Writes use byte enables; reads are lane-selected and then sign- or zero-extended.
- Stalls the CPU until the memory acknowledges the access.
- Sits between the datapath's ALU address output and the data RAM or peripheral bus.

---
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store responder: turns CPU byte/half/word accesses into one word-wide
// ready/ack memory transaction and stalls the CPU until it completes.
module mem_access_unit #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [1:0]        memDataSize,
    input  logic              memBitExt,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              memErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] timeoutCnt;
    logic [1:0]       sizeQ;
    logic [1:0]       laneQ;
    logic             extQ;
    logic             timedOut;

    logic access;
    logic illegal;
    logic startAccess;

    // Upper address bits lie outside the attached memory window.
    logic unusedAddrBits;
    assign unusedAddrBits = ^addr[31:ADDR_W+2];

    function automatic logic [3:0] byteEnables(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicateStore(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] extendLoad(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic zeroExt);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: return {zeroExt ? 24'h0 : {24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: return {zeroExt ? 16'h0 : {16{shifted[15]}}, shifted[15:0]};
            default: return word;
        endcase
    endfunction

    assign access  = memRead | memWrite;
    assign illegal = (memRead & memWrite)
                   | (memDataSize == 2'b11)
                   | ((memDataSize == SZ_HALF) & addr[0])
                   | ((memDataSize == SZ_WORD) & (addr[1:0] != 2'b00));
    assign startAccess = (state == IDLE) & access & ~illegal;

    always_comb begin
        stall  = 1'b0;
        memErr = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    stall  = access & ~illegal;
                    memErr = access & illegal;
                end
                BUSY:    stall  = 1'b1;
                DONE:    memErr = timedOut;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            timeoutCnt <= '0;
            timedOut   <= 1'b0;
            sizeQ      <= '0;
            laneQ      <= '0;
            extQ       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startAccess) begin
                        mem_req    <= 1'b1;
                        mem_we     <= memWrite;
                        mem_addr   <= addr[ADDR_W+1:2];
                        mem_be     <= byteEnables(memDataSize, addr[1:0]);
                        mem_wdata  <= replicateStore(memDataSize, wdata);
                        sizeQ      <= memDataSize;
                        laneQ      <= addr[1:0];
                        extQ       <= memBitExt;
                        timeoutCnt <= '0;
                        timedOut   <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rdata <= extendLoad(mem_rdata, sizeQ, laneQ, extQ);
                        end
                        state <= DONE;
                    end else if ((TIMEOUT != 0) && (timeoutCnt == CNT_LAST)) begin
                        // Abandoned access: report zero data and flag the error for DONE.
                        mem_req  <= 1'b0;
                        rdata    <= '0;
                        timedOut <= 1'b1;
                        state    <= DONE;
                    end else begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory model plus a
// word-wide memory responder, directed scenarios and randomized traffic.
module tb_mem_access_unit;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              rst;
    logic              memRead;
    logic              memWrite;
    logic [1:0]        memDataSize;
    logic              memBitExt;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              stall;
    logic              memErr;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expRdata;

    logic [31:0] ram    [0:1023];
    logic [7:0]  refMem [0:255];

    typedef struct {
        int              stallCycles;
        int              reqCycles;
        logic            stallFirst;
        logic            errFirst;
        logic            errEnd;
        logic [31:0]     rdataEnd;
        logic [ADDR_W-1:0] addrCap;
        logic [3:0]      beCap;
        logic            weCap;
        logic [31:0]     wdCap;
        logic            unstable;
        logic            hung;
    } obs_t;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
        .memDataSize(memDataSize), .memBitExt(memBitExt), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .memErr(memErr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sizeBytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] modelLoad(input int a, input int n, input logic zeroExt);
        longint v = 0;
        for (int k = 0; k < n; k++) v += longint'(refMem[a + k]) << (8 * k);
        if (!zeroExt && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic modelStore(input int a, input int n, input logic [31:0] wd);
        for (int k = 0; k < n; k++) refMem[a + k] = wd[8 * k +: 8];
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        ram[a >> 2] = v;
        for (int k = 0; k < 4; k++) refMem[a + k] = v[8 * k +: 8];
    endtask

    // Presents one CPU access, answers it as the memory would, and records what was seen.
    task automatic runAccess(input logic rd, input logic wr, input logic [1:0] sz, input logic ext,
                             input logic [31:0] a, input logic [31:0] wd, input int ackDelay,
                             output obs_t o);
        bit finished = 0;
        o.stallCycles = 0; o.reqCycles = 0; o.stallFirst = 0; o.errFirst = 0; o.errEnd = 0;
        o.rdataEnd = '0; o.addrCap = '0; o.beCap = '0; o.weCap = 0; o.wdCap = '0;
        o.unstable = 0; o.hung = 0;
        @(negedge clk);
        memRead = rd; memWrite = wr; memDataSize = sz; memBitExt = ext;
        addr = a; wdata = wd; mem_ack = 1'b0;
        #1;
        o.stallFirst = stall;
        o.errFirst   = memErr;
        for (int cyc = 0; cyc < 40; cyc++) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (o.reqCycles == 0) begin
                    o.addrCap = mem_addr; o.beCap = mem_be; o.weCap = mem_we; o.wdCap = mem_wdata;
                end else if (o.addrCap !== mem_addr || o.beCap !== mem_be ||
                             o.weCap !== mem_we || o.wdCap !== mem_wdata) begin
                    o.unstable = 1;
                end
                o.reqCycles++;
                if (ackDelay != 0 && o.reqCycles == ackDelay) begin
                    if (mem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_be[i]) ram[mem_addr][8 * i +: 8] = mem_wdata[8 * i +: 8];
                    end
                    mem_rdata = ram[mem_addr];
                    mem_ack   = 1'b1;
                end
            end
            if (stall) begin
                o.stallCycles++;
            end else begin
                o.errEnd   = memErr;
                o.rdataEnd = rdata;
                finished   = 1;
                break;
            end
            @(negedge clk); #1;
        end
        if (!finished) o.hung = 1;
        memRead = 1'b0; memWrite = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; memRead = 1'b1; memDataSize = 2'd0; addr = 32'h0;
        @(negedge clk); #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        total++; if (memErr !== 1'b0) begin bad++; $display("FAIL reset_memErr: got %b want 0", memErr); end
        @(negedge clk); #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
        total++; if (mem_be !== 4'h0) begin bad++; $display("FAIL reset_be: got %h want 0", mem_be); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        rst = 1'b0; memRead = 1'b0;
        expRdata = 32'h0;
    endtask

    task automatic test_word_store;
        obs_t o;
        runAccess(1'b0, 1'b1, 2'd0, 1'b0, 32'h10, 32'hDEADBEEF, 3, o);
        modelStore(32'h10, 4, 32'hDEADBEEF);
        total++; if (o.addrCap !== 10'd4) begin bad++; $display("FAIL sw_addr: got %h want 4", o.addrCap); end
        total++; if (o.beCap !== 4'hF) begin bad++; $display("FAIL sw_be: got %h want f", o.beCap); end
        total++; if (o.weCap !== 1'b1) begin bad++; $display("FAIL sw_we: got %b want 1", o.weCap); end
        total++; if (o.wdCap !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata: got %h want deadbeef", o.wdCap); end
        total++; if (o.stallCycles != 4) begin bad++; $display("FAIL sw_stall: got %0d want 4", o.stallCycles); end
        total++; if (o.reqCycles != 3) begin bad++; $display("FAIL sw_req: got %0d want 3", o.reqCycles); end
        total++; if (o.errEnd !== 1'b0) begin bad++; $display("FAIL sw_err: got %b want 0", o.errEnd); end
        total++; if (o.rdataEnd !== expRdata) begin bad++; $display("FAIL sw_rdata: got %h want %h", o.rdataEnd, expRdata); end
        total++; if (o.unstable !== 1'b0) begin bad++; $display("FAIL sw_stable: got %b want 0", o.unstable); end
        runAccess(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1, o);
        expRdata = 32'hDEADBEEF;
        total++; if (o.rdataEnd !== expRdata) begin bad++; $display("FAIL lw_back: got %h want %h", o.rdataEnd, expRdata); end
        total++; if (o.stallCycles != 2) begin bad++; $display("FAIL lw_stall: got %0d want 2", o.stallCycles); end
    endtask

    task automatic test_byte_ext;
        obs_t o;
        preload(32'h20, 32'h80FF7F01);
        runAccess(1'b1, 1'b0, 2'd2, 1'b0, 32'h23, 32'h0, 2, o);
        total++; if (o.rdataEnd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb3_sign: got %h want ffffff80", o.rdataEnd); end
        total++; if (o.beCap !== 4'b1000) begin bad++; $display("FAIL lb3_be: got %b want 1000", o.beCap); end
        runAccess(1'b1, 1'b0, 2'd2, 1'b1, 32'h23, 32'h0, 1, o);
        total++; if (o.rdataEnd !== 32'h00000080) begin bad++; $display("FAIL lb3_zero: got %h want 00000080", o.rdataEnd); end
        runAccess(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1, o);
        total++; if (o.rdataEnd !== 32'h00000001) begin bad++; $display("FAIL lb0_sign: got %h want 00000001", o.rdataEnd); end
        expRdata = 32'h00000001;
    endtask

    task automatic test_half;
        obs_t o;
        runAccess(1'b0, 1'b1, 2'd1, 1'b0, 32'h32, 32'h1234ABCD, 1, o);
        modelStore(32'h32, 2, 32'h1234ABCD);
        total++; if (o.wdCap !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata: got %h want abcdabcd", o.wdCap); end
        total++; if (o.beCap !== 4'b1100) begin bad++; $display("FAIL sh_be: got %b want 1100", o.beCap); end
        preload(32'h30, 32'hF00D1234);
        runAccess(1'b1, 1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 2, o);
        total++; if (o.rdataEnd !== 32'hFFFFF00D) begin bad++; $display("FAIL lh_sign: got %h want fffff00d", o.rdataEnd); end
        expRdata = 32'hFFFFF00D;
    endtask

    task automatic test_illegal;
        logic [1:0]  rdwr [4] = '{2'b10, 2'b10, 2'b10, 2'b11};
        logic [1:0]  szs  [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
        logic [31:0] adrs [4] = '{32'h46, 32'h41, 32'h40, 32'h40};
        obs_t o;
        for (int t = 0; t < 4; t++) begin
            runAccess(rdwr[t][1], rdwr[t][0], szs[t], 1'b0, adrs[t], 32'h55AA55AA, 1, o);
            #1;
            total++; if (o.errFirst !== 1'b1) begin bad++; $display("FAIL ill%0d_err: got %b want 1", t, o.errFirst); end
            total++; if (o.stallFirst !== 1'b0) begin bad++; $display("FAIL ill%0d_stall: got %b want 0", t, o.stallFirst); end
            total++; if (o.reqCycles != 0) begin bad++; $display("FAIL ill%0d_req: got %0d want 0", t, o.reqCycles); end
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ill%0d_reqafter: got %b want 0", t, mem_req); end
            total++; if (o.rdataEnd !== expRdata) begin bad++; $display("FAIL ill%0d_rdata: got %h want %h", t, o.rdataEnd, expRdata); end
        end
    endtask

    task automatic test_timeout;
        obs_t o;
        runAccess(1'b1, 1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 0, o);
        expRdata = 32'h0;
        total++; if (o.reqCycles != TIMEOUT) begin bad++; $display("FAIL to_req: got %0d want %0d", o.reqCycles, TIMEOUT); end
        total++; if (o.stallCycles != TIMEOUT + 1) begin bad++; $display("FAIL to_stall: got %0d want %0d", o.stallCycles, TIMEOUT + 1); end
        total++; if (o.errEnd !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", o.errEnd); end
        total++; if (o.rdataEnd !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 0", o.rdataEnd); end
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL late_ack_req: got %b want 0", mem_req); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL late_ack_stall: got %b want 0", stall); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL late_ack_rdata: got %h want 0", rdata); end
        total++; if (memErr !== 1'b0) begin bad++; $display("FAIL late_ack_err: got %b want 0", memErr); end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_busy;
        obs_t o;
        int waited = 0;
        @(negedge clk);
        memRead = 1'b1; memWrite = 1'b0; memDataSize = 2'd0; addr = 32'h10; mem_ack = 1'b0;
        #1;
        while (!mem_req && waited < 10) begin @(negedge clk); #1; waited++; end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rb_reqwait: got %b want 1", mem_req); end
        rst = 1'b1;
        @(negedge clk); #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rb_req: got %b want 0", mem_req); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rb_stall: got %b want 0", stall); end
        total++; if (mem_be !== 4'h0) begin bad++; $display("FAIL rb_be: got %h want 0", mem_be); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rb_rdata: got %h want 0", rdata); end
        rst = 1'b0; memRead = 1'b0;
        expRdata = 32'h0;
        runAccess(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1, o);
        expRdata = modelLoad(32'h10, 4, 1'b0);
        total++; if (o.rdataEnd !== expRdata) begin bad++; $display("FAIL rb_lw: got %h want %h", o.rdataEnd, expRdata); end
        total++; if (o.stallCycles != 2) begin bad++; $display("FAIL rb_lw_stall: got %0d want 2", o.stallCycles); end
        total++; if (o.errEnd !== 1'b0) begin bad++; $display("FAIL rb_lw_err: got %b want 0", o.errEnd); end
    endtask

    task automatic test_random;
        obs_t o;
        for (int it = 0; it < 80; it++) begin
            int r, s, a, n, dly;
            logic rd, wr, ext, legal;
            logic [1:0] sz;
            logic [31:0] wd, expWd;
            logic [3:0] expBe;
            r   = $urandom_range(0, 7);
            rd  = (r < 3) || (r == 7);
            wr  = (r >= 3);
            s   = $urandom_range(0, 15);
            sz  = (s == 15) ? 2'd3 : 2'(s % 3);
            n   = sizeBytes(sz);
            a   = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a - (a % n);
            ext = 1'($urandom_range(0, 1));
            wd  = $urandom;
            dly = $urandom_range(1, 3);
            legal = !(rd && wr) && (sz != 2'd3) && (a % n == 0);
            expBe = 4'(((1 << n) - 1) << (a % 4));
            expWd = (n == 4) ? wd : (n == 2) ? wd[15:0] * 32'h00010001 : wd[7:0] * 32'h01010101;
            runAccess(rd, wr, sz, ext, 32'(a), wd, dly, o);
            total++; if (o.hung !== 1'b0) begin bad++; $display("FAIL rnd%0d_hung: got %b want 0", it, o.hung); end
            if (legal) begin
                if (wr) modelStore(a, n, wd);
                else expRdata = modelLoad(a, n, ext);
                total++; if (o.stallCycles != dly + 1) begin bad++; $display("FAIL rnd%0d_stall: got %0d want %0d", it, o.stallCycles, dly + 1); end
                total++; if (o.errEnd !== 1'b0) begin bad++; $display("FAIL rnd%0d_err: got %b want 0", it, o.errEnd); end
                total++; if (o.addrCap !== ADDR_W'(a / 4)) begin bad++; $display("FAIL rnd%0d_addr: got %h want %h", it, o.addrCap, a / 4); end
                total++; if (o.beCap !== expBe) begin bad++; $display("FAIL rnd%0d_be: got %b want %b", it, o.beCap, expBe); end
                total++; if (o.weCap !== wr) begin bad++; $display("FAIL rnd%0d_we: got %b want %b", it, o.weCap, wr); end
                if (wr) begin
                    total++; if (o.wdCap !== expWd) begin bad++; $display("FAIL rnd%0d_wdata: got %h want %h", it, o.wdCap, expWd); end
                end
                total++; if (o.unstable !== 1'b0) begin bad++; $display("FAIL rnd%0d_stable: got %b want 0", it, o.unstable); end
            end else begin
                total++; if (o.errFirst !== 1'b1) begin bad++; $display("FAIL rnd%0d_illerr: got %b want 1", it, o.errFirst); end
                total++; if (o.reqCycles != 0) begin bad++; $display("FAIL rnd%0d_illreq: got %0d want 0", it, o.reqCycles); end
            end
            total++; if (o.rdataEnd !== expRdata) begin bad++; $display("FAIL rnd%0d_rdata: got %h want %h", it, o.rdataEnd, expRdata); end
        end
    endtask

    initial begin
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; memDataSize = 2'd0; memBitExt = 1'b0;
        addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        for (int i = 0; i < 256; i++) refMem[i] = 8'h0;
        test_reset;
        test_word_store;
        test_byte_ext;
        test_half;
        test_illegal;
        test_timeout;
        test_reset_busy;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
